// File: rtl/divider_pkg.sv
// Shared definitions for the serial restoring divider: FSM encoding,
// default operand width and the iteration counter width helper.
package divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // The counter has to hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cntWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and emit the quotient bit.
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rIn,
    input  logic             qMsb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   rNext,
    output logic             qBit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dExt;

    // Trial subtraction on a WIDTH+1 bit value so the compare never overflows.
    always_comb begin
        shifted = {rIn, qMsb};
        dExt    = {1'b0, d};
        rNext   = shifted;
        qBit    = 1'b0;
        if (shifted >= dExt) begin
            rNext = shifted - dExt;
            qBit  = 1'b1;
        end
    end

endmodule

// File: rtl/serial_divider.sv
// Multi-cycle unsigned restoring divider. One quotient bit is produced per
// clock in RUN; results are registered and announced with a one-cycle Done.
module serial_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivZero
);

    localparam int CW = cntWidth(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state;
    logic [WIDTH:0]   rAcc;
    logic [WIDTH-1:0] qReg;
    logic [WIDTH-1:0] dReg;
    logic [CW-1:0]    iterCnt;
    logic [WIDTH:0]   rNext;
    logic             qBit;

    // The accumulator MSB only exists to keep the trial compare exact; after a
    // restoring step the remainder always fits in WIDTH bits.
    logic unusedRMsb;
    assign unusedRMsb = rAcc[WIDTH];

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rIn  (rAcc[WIDTH-1:0]),
        .qMsb (qReg[WIDTH-1]),
        .d    (dReg),
        .rNext(rNext),
        .qBit (qBit)
    );

    // Control FSM plus datapath registers; the Done cycle itself still refuses
    // a new Start so a request made while Done is high is dropped, not queued.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            rAcc      <= '0;
            qReg      <= '0;
            dReg      <= '0;
            iterCnt   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivZero   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start && !Done) begin
                        qReg    <= Dividend;
                        dReg    <= Divisor;
                        rAcc    <= '0;
                        iterCnt <= CNT_LOAD;
                        Busy    <= 1'b1;
                        state   <= (Divisor == '0) ? FINISH : RUN;
                    end
                end
                RUN: begin
                    rAcc    <= rNext;
                    qReg    <= {qReg[WIDTH-2:0], qBit};
                    iterCnt <= iterCnt - CNT_ONE;
                    if (iterCnt == CNT_ONE) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= IDLE;
                    if (dReg == '0) begin
                        Quotient  <= '1;
                        Remainder <= qReg;
                        DivZero   <= 1'b1;
                    end else begin
                        Quotient  <= qReg;
                        Remainder <= rAcc[WIDTH-1:0];
                        DivZero   <= 1'b0;
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
